regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file, successor to the single-write/dual-read CPU register file. Sits between decode (read addresses) and writeback (write port). Adds configurable width, depth and read-port count, per-port read enable for pipeline stalls, write-to-read bypass, and a reset-driven sequential clear. Reads are registered with one-cycle latency, matching the existing pipeline timing.

## Interface
Parameters:
- XLEN, 32, data width in bits (≥8)
- NREGS, 32, number of architectural registers (power of 2, ≥4); register 0 is hardwired zero
- NREAD, 2, number of read ports (1–4)
- AW, $clog2(NREGS), address width (derived; do not override)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- we  in  1  write enable
- waddr  in  AW  write destination register
- wdata  in  XLEN  write data (writeback mux lives outside this block)
- ren  in  NREAD  per-port read enable; bit i gates port i
- raddr  in  NREAD*AW  packed read addresses; port i at [i*AW +: AW]
- rdata  out  NREAD*XLEN  packed registered read data; port i at [i*XLEN +: XLEN]
- busy  out  1  high while the clear sequence runs; all other inputs are ignored

## Operation
- FSM states: CLEAR, RUN. State is a register; busy = (state == CLEAR).
- rst=1 at a posedge: state←CLEAR, clear index←1, all rdata←0. rst held high keeps the block in CLEAR with index 1.
- CLEAR: each cycle writes 0 to register[index], then index increments. After writing NREGS-1, state←RUN. we, ren and raddr are ignored, and rdata holds 0.
- rst asserted mid-clear restarts the clear at index 1.
- RUN write: if we && waddr≠0, register[waddr]←wdata at the posedge. Writes to register 0 are dropped.
- RUN read, port i with ren[i]=1: rdata_i is loaded at the posedge with:
  - 0 if raddr_i==0;
  - else wdata if we && waddr==raddr_i (bypass: same-cycle write is visible);
  - else register[raddr_i].
- ren[i]=0: rdata_i holds its previous value (stall). Bypass does not apply to a held value.
- Multiple ports may read the same address in the same cycle. All of them receive identical data, including the bypassed value.
- Register 0 reads as 0 for every port under all conditions. No storage is required for it.

## Timing
- Read latency: 1 cycle (address at edge N → data valid after edge N+1).
- Write→read same cycle: new data appears on rdata after that same edge (bypass). Write at edge N, read issued at N+1: served from storage.
- Clear duration: NREGS-1 cycles after the first posedge with rst=0. busy falls on the edge that writes register NREGS-1. The first accepted read or write is on the next edge.
- Output reset values: rdata = 0 and busy = 1 from the first reset edge onward.
- Inputs are sampled only on posedge. There are no combinational paths from inputs to outputs.

## Structure
- Shared package regfile_pkg holds:
  - XLEN_DEFAULT=32 and NREGS_DEFAULT=32;
  - the state enum type rf_state_t {CLEAR, RUN};
  - the zero-register constant REG_ZERO='0.
- Storage array, clear FSM and write logic live in regfile_mp.
- Sub-module regfile_read_port (params XLEN, AW) is instantiated NREAD times by generate. It contains:
  - inputs: storage word, raddr, ren, we/waddr/wdata, busy, rst;
  - the bypass/zero/hold mux and the rdata register.

## Test plan
- Reset then clear: preload via backdoor, pulse rst 1 cycle. Require busy=1 for exactly 31 cycles (NREGS=32), all reads afterwards return 0, and rdata=0 during the clear.
- Basic write/read: write x5←0xDEADBEEF, read port0 x5 next cycle. Require 0xDEADBEEF one cycle later. Writing x0←0x1234 and reading x0 returns 0.
- Bypass: in the same cycle, we x7←0xA5A5A5A5 and both ports read x7. Require both rdata=0xA5A5A5A5 after that edge.
- Stall: port1 reads x3=0x11 with ren[1]=1, then ren[1]=0 while x3←0x22 and raddr changes. Require rdata1 to stay 0x11 until ren[1] returns to 1, then show 0x22.
- Reset mid-clear: assert rst at clear index 10. Require the clear to restart from 1, busy to stay high 31 more cycles, and writes during busy to be ignored (register reads 0 afterwards).
- Parameter sweep: XLEN=64, NREGS=16, NREAD=3, all ports reading distinct and identical addresses. Require correct packed slices and a clear time of 15 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_t;

    localparam int unsigned REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: zero-register, write bypass and stall hold in front of the rdata flop.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            busy,
    input  logic            ren,
    input  logic [AW-1:0]   raddr,
    input  logic [XLEN-1:0] rword,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (busy) begin
            rdata_d = XLEN'(REG_ZERO);
        end else if (ren) begin
            if (raddr == '0)
                rdata_d = XLEN'(REG_ZERO);
            else if (we && (waddr == raddr))
                rdata_d = wdata;
            else
                rdata_d = rword;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rdata_q <= XLEN'(REG_ZERO);
        else
            rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write bypass and a sequential clear after reset.
//   state | meaning
//   CLEAR | zeroing register[idx] each cycle, 1..NREGS-1; inputs ignored, busy high
//   RUN   | normal write/read operation
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NREAD-1:0]      ren,
    input  logic [NREAD*AW-1:0]   raddr,
    output logic [NREAD*XLEN-1:0] rdata,
    output logic                  busy
);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wr_en;
    logic [XLEN-1:0] mem_q [1:NREGS-1];
    logic [XLEN-1:0] mem_d [1:NREGS-1];
    logic [XLEN-1:0] rf_word [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (state_q == CLEAR) begin
            idx_d = idx_q + AW'(1);
            if (idx_q == AW'(NREGS - 1))
                state_d = RUN;
        end
    end

    always_comb begin
        busy  = (state_q == CLEAR);
        wr_en = (state_q == RUN) && !rst && we && (waddr != '0);
    end

    // Storage carries no reset; the clear sequence zeroes it instead.
    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            mem_d[i] = mem_q[i];
            if (busy && (idx_q == AW'(i)))
                mem_d[i] = '0;
            else if (wr_en && (waddr == AW'(i)))
                mem_d[i] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        rf_word[0] = XLEN'(REG_ZERO);
        for (int i = 1; i < NREGS; i++)
            rf_word[i] = mem_q[i];
    end

    for (genvar p = 0; p < NREAD; p++) begin : gen_rd
        regfile_read_port #(
            .XLEN (XLEN),
            .AW   (AW)
        ) u_rp (
            .clk   (clk),
            .rst   (rst),
            .busy  (busy),
            .ren   (ren[p]),
            .raddr (raddr[p*AW +: AW]),
            .rword (rf_word[raddr[p*AW +: AW]]),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .rdata (rdata[p*XLEN +: XLEN])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x32x2 instance plus a 64x16x3 instance.
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  ren = '0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic        busy;

    logic         rst2 = 1'b1;
    logic         we2 = 1'b0;
    logic [3:0]   waddr2 = '0;
    logic [63:0]  wdata2 = '0;
    logic [2:0]   ren2 = '0;
    logic [11:0]  raddr2 = '0;
    logic [191:0] rdata2;
    logic         busy2;

    regfile_mp dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .ren(ren), .raddr(raddr), .rdata(rdata), .busy(busy)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NREAD(3)) dut64 (
        .clk(clk), .rst(rst2), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .ren(ren2), .raddr(raddr2), .rdata(rdata2), .busy(busy2)
    );

    int tests = 0;
    int errors = 0;
    logic zero_bad;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  ren;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until busy drops (bounded); flags any nonzero rdata seen meanwhile.
    task automatic count_clear(input int which, output int n);
        n = 0;
        zero_bad = 1'b0;
        while (((which == 0) ? busy : busy2) && n < 100) begin
            tick();
            n++;
            if (which == 0 && rdata !== 64'h0) zero_bad = 1'b1;
            if (which == 1 && rdata2 !== 192'h0) zero_bad = 1'b1;
        end
    endtask

    initial begin
        int n;

        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        2'b01, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b1, 5'd0,  32'h00001234, 2'b11, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
        vecs[4]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 2'b11, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[5]  = '{1'b1, 5'd3,  32'h00000011, 2'b00, 5'd0,  5'd0,  32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd0,  5'd3,  32'hA5A5A5A5, 32'h00000011};
        vecs[7]  = '{1'b1, 5'd3,  32'h00000022, 2'b00, 5'd0,  5'd9,  32'hA5A5A5A5, 32'h00000011};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd4,  32'hA5A5A5A5, 32'h00000011};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        2'b10, 5'd0,  5'd3,  32'hA5A5A5A5, 32'h00000022};
        vecs[10] = '{1'b1, 5'd31, 32'hFFFFFFFF, 2'b11, 5'd31, 5'd7,  32'hFFFFFFFF, 32'hA5A5A5A5};
        vecs[11] = '{1'b1, 5'd31, 32'h12345678, 2'b01, 5'd31, 5'd0,  32'h12345678, 32'hA5A5A5A5};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        2'b11, 5'd31, 5'd5,  32'h12345678, 32'hDEADBEEF};
        vecs[13] = '{1'b1, 5'd6,  32'h00000066, 2'b11, 5'd5,  5'd6,  32'hDEADBEEF, 32'h00000066};
        vecs[14] = '{1'b1, 5'd0,  32'hFFFFFFFF, 2'b01, 5'd0,  5'd0,  32'h0,        32'h00000066};

        // Reset values, then the initial clear with reads requested throughout.
        tick();
        tick();
        check("reset_busy", {63'h0, busy}, 64'h1);
        check("reset_rdata", rdata, 64'h0);
        ren = 2'b11;
        raddr = {5'd7, 5'd5};
        rst = 1'b0;
        count_clear(0, n);
        check("clear_len", 64'(n), 64'd31);
        check("clear_rdata_zero", {63'h0, zero_bad}, 64'h0);

        for (int i = 0; i < 15; i++) begin
            we = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            ren = vecs[i].ren;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            tick();
            check($sformatf("vec%0d_port0", i), {32'h0, rdata[31:0]}, {32'h0, vecs[i].e0});
            check($sformatf("vec%0d_port1", i), {32'h0, rdata[63:32]}, {32'h0, vecs[i].e1});
        end

        // Reset pulse over populated storage; writes during the clear must be dropped.
        we = 1'b0;
        ren = 2'b11;
        raddr = {5'd7, 5'd5};
        rst = 1'b1;
        tick();
        check("pulse_busy", {63'h0, busy}, 64'h1);
        check("pulse_rdata", rdata, 64'h0);
        rst = 1'b0;
        we = 1'b1;
        waddr = 5'd5;
        wdata = 32'h00000055;
        count_clear(0, n);
        check("pulse_clear_len", 64'(n), 64'd31);
        check("pulse_rdata_zero", {63'h0, zero_bad}, 64'h0);
        we = 1'b0;
        tick();
        check("post_clear_x5_x7", rdata, 64'h0);
        raddr = {5'd3, 5'd31};
        tick();
        check("post_clear_x31_x3", rdata, 64'h0);

        // Reset again at clear index 10; the restart must take the full 31 cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1;
        waddr = 5'd9;
        wdata = 32'h00000BAD;
        raddr = {5'd5, 5'd9};
        for (int i = 0; i < 9; i++) tick();
        check("mid_busy", {63'h0, busy}, 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waddr = 5'd5;
        count_clear(0, n);
        check("mid_restart_len", 64'(n), 64'd31);
        check("mid_rdata_zero", {63'h0, zero_bad}, 64'h0);
        we = 1'b0;
        tick();
        check("mid_x9_x5_zero", rdata, 64'h0);

        // 64-bit, 16-register, 3-port instance.
        rst2 = 1'b0;
        count_clear(1, n);
        check("w64_clear_len", 64'(n), 64'd15);
        we2 = 1'b1;
        waddr2 = 4'd1;
        wdata2 = 64'h0123456789ABCDEF;
        ren2 = 3'b000;
        tick();
        waddr2 = 4'd15;
        wdata2 = 64'hFEDCBA9876543210;
        ren2 = 3'b111;
        raddr2 = {4'd0, 4'd15, 4'd1};
        tick();
        check("w64_p0_x1", rdata2[63:0], 64'h0123456789ABCDEF);
        check("w64_p1_x15_bypass", rdata2[127:64], 64'hFEDCBA9876543210);
        check("w64_p2_x0", rdata2[191:128], 64'h0);
        waddr2 = 4'd9;
        wdata2 = 64'hCAFEF00D12345678;
        raddr2 = {4'd9, 4'd9, 4'd9};
        tick();
        check("w64_p0_bypass", rdata2[63:0], 64'hCAFEF00D12345678);
        check("w64_p1_bypass", rdata2[127:64], 64'hCAFEF00D12345678);
        check("w64_p2_bypass", rdata2[191:128], 64'hCAFEF00D12345678);
        we2 = 1'b0;
        ren2 = 3'b101;
        raddr2 = {4'd9, 4'd1, 4'd15};
        tick();
        check("w64_p0_x15", rdata2[63:0], 64'hFEDCBA9876543210);
        check("w64_p1_hold", rdata2[127:64], 64'hCAFEF00D12345678);
        check("w64_p2_x9", rdata2[191:128], 64'hCAFEF00D12345678);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
